// File: rtl/seq_pattern_counter.sv
// seq_pattern_counter: counts non-overlapping occurrences of PATTERN in a strobed serial bit stream.
// Build option: define SEQ_PATTERN_OVERLAP_EN for overlapping counting (HOLD never entered).
// Ports:
//   clock_100Mhz      - system clock, rising edge
//   reset             - asynchronous active-high reset
//   bit_in            - serial data from the pattern ROM (douta), sampled on the strobe
//   one_second_enable - one-cycle bit-accept strobe
//   count_clear       - synchronous clear of count, history, overflow and FSM
//   pattern_count     - registered 8-bit match count (wraps 255->0)
//   match_pulse       - one-cycle pulse after each counted match
//   overflow          - sticky flag, set when the count wraps
//   state_dbg         - FSM state: 00 FILL, 01 ARMED, 10 HOLD
module seq_pattern_counter #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       one_second_enable,
    input  logic       count_clear,
    output logic [7:0] pattern_count,
    output logic       match_pulse,
    output logic       overflow,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {FILL = 2'b00, ARMED = 2'b01, HOLD = 2'b10} state_t;
    localparam logic [3:0] LEN = 4'(PATTERN_LEN);

    state_t                 state_q, state_d;
    logic [PATTERN_LEN-1:0] hist_q, hist_d, hist_next;
    logic [3:0]             bs_q, bs_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   pulse_q, pulse_d, ovf_q, ovf_d;
    logic                   full, cand, elig, hit;

    always_comb begin
        hist_next = {hist_q[PATTERN_LEN-2:0], bit_in};
        // full: the bit being accepted is at least the PATTERN_LEN-th since the last reference point
        full      = (bs_q + 4'd1) >= LEN;
        cand      = hist_next == PATTERN;
`ifdef SEQ_PATTERN_OVERLAP_EN
        elig      = full || state_q == ARMED;
`else
        elig      = full;
`endif
        hit       = one_second_enable && cand && elig;
        state_d   = state_q;
        hist_d    = hist_q;
        bs_d      = bs_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        pulse_d   = 1'b0;
        if (count_clear) begin
            state_d = FILL;
            hist_d  = '0;
            bs_d    = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (one_second_enable) begin
                hist_d  = hist_next;
                pulse_d = hit;
                if (hit) begin
                    bs_d    = '0;
                    cnt_d   = cnt_q + 8'd1;
                    ovf_d   = ovf_q || cnt_q == 8'hff;
`ifdef SEQ_PATTERN_OVERLAP_EN
                    state_d = ARMED;
`else
                    state_d = HOLD;
`endif
                end else begin
                    bs_d    = full ? LEN : bs_q + 4'd1;
                    state_d = full ? ARMED : state_q;
                end
            end
            // illegal encoding 11 restarts the fill phase
            if (state_q == state_t'(2'b11)) begin
                state_d = FILL;
                bs_d    = '0;
            end
        end
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            hist_q  <= '0;
            bs_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            bs_q    <= bs_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            pulse_q <= pulse_d;
        end
    end

    assign pattern_count = cnt_q;
    assign match_pulse   = pulse_q;
    assign overflow      = ovf_q;
    assign state_dbg     = state_q;
endmodule
